// File: rtl/stack_param_if.sv
// stack_param_if: command/data/status bundle between a stack_param and its driver
interface stack_param_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 5,
  parameter int unsigned IDX_W = 3
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  logic [1:0]       COMMAND;
  logic [IDX_W-1:0] INDEX;
  logic [WIDTH-1:0] I_DATA;
  logic [WIDTH-1:0] O_DATA;
  logic [CW-1:0]    COUNT;
  logic             FULL;
  logic             EMPTY;
  logic             ERROR;
  modport master (output COMMAND, INDEX, I_DATA, input O_DATA, COUNT, FULL, EMPTY, ERROR);
  modport slave  (input COMMAND, INDEX, I_DATA, output O_DATA, COUNT, FULL, EMPTY, ERROR);
endinterface

// File: rtl/stack_param.sv
// stack_param: parameterised LIFO with circular/saturating overflow; define STACK_ERR_STICKY_EN for a sticky ERROR
module stack_param #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned DEPTH     = 5,
  parameter int unsigned IDX_W     = 3,
  parameter bit          WRAP_MODE = 1'b1
) (
  input logic         CLK,
  input logic         RESET,
  stack_param_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    hp, hp_n, hp_inc, hp_dec, rd_addr;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] dout, dout_n;
  logic             err, err_n, err_base, we, full, empty, in_range;
  logic [31:0]      idx_mod, rd_sum;
`ifdef STACK_ERR_STICKY_EN
  assign err_base = err;
`else
  assign err_base = 1'b0;
`endif
  assign full       = cnt == CW'(DEPTH);
  assign empty      = cnt == '0;
  assign bus.O_DATA = dout;
  assign bus.COUNT  = cnt;
  assign bus.FULL   = full;
  assign bus.EMPTY  = empty;
  assign bus.ERROR  = err;
  // modulo-DEPTH pointer neighbours and the get address, safe for non-power-of-two DEPTH
  always_comb begin
    hp_inc   = (32'(hp) == DEPTH - 1) ? '0 : hp + 1'b1;
    hp_dec   = (hp == '0) ? PW'(DEPTH - 1) : hp - 1'b1;
    idx_mod  = 32'(bus.INDEX) % DEPTH;
    rd_sum   = 32'(hp) + DEPTH - 32'd1 - idx_mod;
    rd_addr  = PW'((rd_sum >= DEPTH) ? rd_sum - DEPTH : rd_sum);
    in_range = WRAP_MODE || (32'(bus.INDEX) < 32'(cnt));
  end
  // next-state decode of the current command
  always_comb begin
    hp_n   = hp;
    cnt_n  = cnt;
    dout_n = dout;
    err_n  = err_base;
    we     = 1'b0;
    case (bus.COMMAND)
      2'd1: begin
        we    = !full || WRAP_MODE;
        hp_n  = we ? hp_inc : hp;
        cnt_n = full ? cnt : cnt + 1'b1;
        err_n = err_base | !we;
      end
      2'd2: begin
        dout_n = (!empty || WRAP_MODE) ? mem[hp_dec] : '0;
        hp_n   = (!empty || WRAP_MODE) ? hp_dec : hp;
        cnt_n  = empty ? cnt : cnt - 1'b1;
        err_n  = err_base | empty;
      end
      2'd3: begin
        dout_n = in_range ? mem[rd_addr] : '0;
        err_n  = err_base | !in_range;
      end
      default: ;
    endcase
  end
  // state and storage registers; reset wipes every entry
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hp   <= '0;
      cnt  <= '0;
      dout <= '0;
      err  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      hp   <= hp_n;
      cnt  <= cnt_n;
      dout <= dout_n;
      err  <= err_n;
      if (we) mem[hp] <= bus.I_DATA;
    end
  end
endmodule

// File: tb/tb_stack_param.sv
// tb_stack_param: drives a circular and a saturating stack with identical stimulus and checks both against a reference model
module tb_stack_param;
  localparam int D = 5;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  int mm [2][D];
  int m_hp [2];
  int m_cnt [2];
  int m_out [2];
  int m_err [2];
  stack_param_if w0 ();
  stack_param_if w1 ();
  stack_param #(.WRAP_MODE(1'b0)) u0 (.CLK(clk), .RESET(rst), .bus(w0));
  stack_param #(.WRAP_MODE(1'b1)) u1 (.CLK(clk), .RESET(rst), .bus(w1));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic model(input bit r, input int cmd, input int idx, input int data);
    bit sticky = 1'b0;
`ifdef STACK_ERR_STICKY_EN
    sticky = 1'b1;
`endif
    for (int w = 0; w < 2; w++) begin
      int top;
      int a;
      if (r) begin
        for (int k = 0; k < D; k++) mm[w][k] = 0;
        m_hp[w] = 0; m_cnt[w] = 0; m_out[w] = 0; m_err[w] = 0;
        continue;
      end
      m_err[w] = sticky ? m_err[w] : 0;
      top = (m_hp[w] + D - 1) % D;
      a = (m_hp[w] + D - 1 - (idx % D)) % D;
      if (cmd == 1) begin
        if (m_cnt[w] < D || w == 1) begin
          mm[w][m_hp[w]] = data;
          m_hp[w] = (m_hp[w] + 1) % D;
          if (m_cnt[w] < D) m_cnt[w]++;
        end else m_err[w] = 1;
      end else if (cmd == 2) begin
        if (m_cnt[w] > 0) begin
          m_out[w] = mm[w][top]; m_hp[w] = top; m_cnt[w]--;
        end else begin
          m_err[w] = 1;
          m_out[w] = (w == 1) ? mm[w][top] : 0;
          if (w == 1) m_hp[w] = top;
        end
      end else if (cmd == 3) begin
        if (w == 1 || idx < m_cnt[w]) m_out[w] = mm[w][a];
        else begin m_out[w] = 0; m_err[w] = 1; end
      end
    end
  endtask
  task automatic step(input bit r, input int cmd, input int idx, input int data);
    rst = r;
    w0.COMMAND = 2'(cmd); w0.INDEX = 3'(idx); w0.I_DATA = 4'(data);
    w1.COMMAND = 2'(cmd); w1.INDEX = 3'(idx); w1.I_DATA = 4'(data);
    @(posedge clk);
    model(r, cmd, idx, data);
    #1;
    chk("sat_odata", int'(w0.O_DATA), m_out[0]);
    chk("sat_count", int'(w0.COUNT), m_cnt[0]);
    chk("sat_full", int'(w0.FULL), int'(m_cnt[0] == D));
    chk("sat_empty", int'(w0.EMPTY), int'(m_cnt[0] == 0));
    chk("sat_error", int'(w0.ERROR), m_err[0]);
    chk("wrap_odata", int'(w1.O_DATA), m_out[1]);
    chk("wrap_count", int'(w1.COUNT), m_cnt[1]);
    chk("wrap_full", int'(w1.FULL), int'(m_cnt[1] == D));
    chk("wrap_empty", int'(w1.EMPTY), int'(m_cnt[1] == 0));
    chk("wrap_error", int'(w1.ERROR), m_err[1]);
  endtask
  initial begin
    int exp_get [7] = '{3, 2, 1, 0, 0, 3, 2};
    int exp_pop [5] = '{5, 4, 3, 2, 1};
    step(1, 0, 0, 0);
    chk("reset_empty", int'(w1.EMPTY), 1);
    chk("reset_count", int'(w0.COUNT), 0);
    for (int v = 1; v <= 3; v++) step(0, 1, 0, v);
    chk("t1_count", int'(w1.COUNT), 3);
    for (int i = 0; i < 7; i++) begin
      step(0, 3, i, 0);
      chk("t1_get", int'(w1.O_DATA), exp_get[i]);
    end
    for (int i = 0; i < 7; i++) begin
      step(0, 2, 0, 0);
      chk("t1_pop", int'(w1.O_DATA), exp_get[i]);
      chk("t1_pop_err", int'(w1.ERROR), int'(i >= 3));
    end
    step(1, 0, 0, 0);
    for (int v = 1; v <= 7; v++) step(0, 1, 0, v);
    chk("t2_full", int'(w1.FULL), 1);
    chk("t2_err", int'(w1.ERROR), 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 2, 0, 0);
      chk("t2_pop", int'(w1.O_DATA), 7 - i);
    end
    step(1, 0, 0, 0);
    for (int v = 1; v <= 5; v++) step(0, 1, 0, v);
    step(0, 1, 0, 9);
    chk("t3_ovf_err", int'(w0.ERROR), 1);
    chk("t3_ovf_count", int'(w0.COUNT), 5);
    step(0, 3, 0, 0);
    chk("t3_get", int'(w0.O_DATA), 5);
    for (int i = 0; i < 5; i++) begin
      step(0, 2, 0, 0);
      chk("t3_pop", int'(w0.O_DATA), exp_pop[i]);
    end
    step(0, 2, 0, 0);
    chk("t3_unf_err", int'(w0.ERROR), 1);
    chk("t3_unf_data", int'(w0.O_DATA), 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 4); step(0, 1, 0, 8);
    step(0, 3, 1, 0);
    chk("t4_get1", int'(w0.O_DATA), 4);
    step(0, 3, 2, 0);
    chk("t4_get2_err", int'(w0.ERROR), 1);
    step(0, 3, 7, 0);
    chk("t4_get7", int'(w0.O_DATA), 0);
    chk("t4_count", int'(w0.COUNT), 2);
    for (int v = 1; v <= 3; v++) step(0, 1, 0, v);
    step(1, 2, 0, 0);
    chk("t5_count", int'(w1.COUNT), 0);
    step(0, 3, 0, 0);
    chk("t5_get", int'(w1.O_DATA), 0);
    step(0, 2, 0, 0);
    step(0, 1, 0, 3);
    step(0, 3, 0, 0);
    chk("t6_get", int'(w0.O_DATA), 3);
`ifdef STACK_ERR_STICKY_EN
    chk("t6_sticky", int'(w0.ERROR), 1);
`else
    chk("t6_pulse", int'(w0.ERROR), 0);
`endif
    step(1, 0, 0, 0);
    chk("t6_reset_err", int'(w0.ERROR), 0);
    for (int n = 0; n < 600; n++)
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 15));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
